// File: rtl/cc1200_spi_arbiter.sv
// cc1200_spi_arbiter
//   Shares one CC1200 SPI transfer engine between two requesters:
//   requester 0 = CPU register path, requester 1 = hardware RX/status poller.
//   Round-robin grant, one transfer at a time. The winner's command is latched,
//   the engine is started, Busy is tracked to completion, and the read word
//   plus a one-cycle done pulse are returned to the winner.
//
//   Parameters:
//     BUSY_WAIT      cycles allowed for eng_busy to rise after eng_start (1..255)
//     TIMEOUT_CYCLES max cycles eng_busy may stay high (1..65535), only used
//                    when CC1200_SPI_ARB_TIMEOUT_EN is defined
//
//   Ports:
//     clk, rstn              clock, asynchronous active-low reset
//     req[1:0]               per-requester request level
//     req0_data/req0_wr      requester 0 command word / WR field
//     req1_data/req1_wr      requester 1 command word / WR field
//     gnt[1:0]               one-hot grant, held for the whole transfer
//     done[1:0]              one-hot single-cycle completion pulse
//     err                    1 = transfer failed; valid with done, held
//     rdata[31:0]            engine read word; valid with done, held
//     eng_start              single-cycle start pulse to the engine
//     eng_busy               engine busy level
//     eng_dout/eng_wr        command word / WR field to the engine
//     eng_din                read word from the engine
//
//   Optional feature (macro CC1200_SPI_ARB_TIMEOUT_EN):
//     defined   - a stuck-high eng_busy is abandoned after TIMEOUT_CYCLES
//                 cycles with err = 1, rdata = 0
//     undefined - the arbiter waits for eng_busy to fall indefinitely

module cc1200_spi_arbiter #(
  parameter int BUSY_WAIT      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [31:0] req0_data,
  input  logic [3:0]  req0_wr,
  input  logic [31:0] req1_data,
  input  logic [3:0]  req1_wr,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        eng_start,
  input  logic        eng_busy,
  output logic [31:0] eng_dout,
  output logic [3:0]  eng_wr,
  input  logic [31:0] eng_din
);

  generate
    if (BUSY_WAIT < 1 || BUSY_WAIT > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("cc1200_spi_arbiter: BUSY_WAIT or TIMEOUT_CYCLES out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  localparam logic [7:0] BUSY_LIMIT = 8'(BUSY_WAIT);

  state_t      state_reg;
  logic        last_reg;       // index of the most recent winner
  logic        winner_reg;     // index of the requester being served
  logic [1:0]  gnt_reg;
  logic [1:0]  done_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;
  logic        eng_start_reg;
  logic [31:0] eng_dout_reg;
  logic [3:0]  eng_wr_reg;
  logic [7:0]  busy_cnt_reg;

`ifdef CC1200_SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt_reg;
`endif

  // Round-robin choice: a lone requester wins outright; on a tie the
  // requester that did not win last time goes first.
  logic pick;
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11)
      pick = ~last_reg;
    else if (req[1])
      pick = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      winner_reg    <= 1'b0;
      gnt_reg       <= 2'b00;
      done_reg      <= 2'b00;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      eng_start_reg <= 1'b0;
      eng_dout_reg  <= '0;
      eng_wr_reg    <= '0;
      busy_cnt_reg  <= '0;
`ifdef CC1200_SPI_ARB_TIMEOUT_EN
      to_cnt_reg    <= '0;
`endif
    end else begin
      // Pulses default low; they are raised only on the entry edge of
      // LAUNCH / DONE so each lasts exactly one cycle.
      eng_start_reg <= 1'b0;
      done_reg      <= 2'b00;

      case (state_reg)
        IDLE: begin
          if (|req) begin
            winner_reg    <= pick;
            eng_dout_reg  <= pick ? req1_data : req0_data;
            eng_wr_reg    <= pick ? req1_wr : req0_wr;
            gnt_reg       <= {pick, ~pick};
            eng_start_reg <= 1'b1;
            state_reg     <= LAUNCH;
          end
        end

        LAUNCH: begin
          // Busy seen during LAUNCH is deliberately not looked at.
          busy_cnt_reg <= '0;
          state_reg    <= WAIT_HI;
        end

        WAIT_HI: begin
          if (eng_busy) begin
`ifdef CC1200_SPI_ARB_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
            state_reg  <= WAIT_LO;
          end else if (busy_cnt_reg + 8'd1 == BUSY_LIMIT) begin
            // Engine never acknowledged the start.
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            gnt_reg   <= 2'b00;
            done_reg  <= {winner_reg, ~winner_reg};
            state_reg <= DONE;
          end else begin
            busy_cnt_reg <= busy_cnt_reg + 8'd1;
          end
        end

        WAIT_LO: begin
          if (!eng_busy) begin
            err_reg   <= 1'b0;
            rdata_reg <= eng_din;
            gnt_reg   <= 2'b00;
            done_reg  <= {winner_reg, ~winner_reg};
            state_reg <= DONE;
          end
`ifdef CC1200_SPI_ARB_TIMEOUT_EN
          else if (to_cnt_reg + 16'd1 == TIMEOUT_LIMIT) begin
            // Engine is abandoned; its eventual busy fall is never sampled
            // because WAIT_HI is only reached again through LAUNCH.
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            gnt_reg   <= 2'b00;
            done_reg  <= {winner_reg, ~winner_reg};
            state_reg <= DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
          end
`endif
        end

        DONE: begin
          last_reg  <= winner_reg;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign eng_start = eng_start_reg;
  assign eng_dout  = eng_dout_reg;
  assign eng_wr    = eng_wr_reg;

endmodule

// File: doc/cc1200_spi_arbiter.md
Name: cc1200_spi_arbiter

Overview:
- Shares the single CC1200 SPI transfer engine between two requesters: requester 0 is the CPU-side register path; requester 1 is the hardware RX/status poller.
- Engine interface: Start pulse, Busy level, DataOut/DataIn words, WR nibble.
- Grants one transfer at a time using round-robin. Latches the winner's command, launches the engine, tracks Busy to completion, then returns the read word and a done pulse to the winner.

Parameters:
- BUSY_WAIT, 8: max cycles after eng_start for eng_busy to rise before the transfer is flagged as failed (1..255).
- TIMEOUT_CYCLES, 65535: max cycles eng_busy may stay high (used only with the optional feature; 1..65535).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  2  per-requester transfer request (level)
- req0_data  in  32  requester 0 command word
- req0_wr  in  4  requester 0 WR field
- req1_data  in  32  requester 1 command word
- req1_wr  in  4  requester 1 WR field
- gnt  out  2  one-hot grant, held for the whole transfer
- done  out  2  one-hot single-cycle completion pulse
- err  out  1  valid with done; 1 = transfer failed
- rdata  out  32  engine read word, valid with done, held until next done
- eng_start  out  1  single-cycle start pulse to engine
- eng_busy  in  1  engine busy
- eng_dout  out  32  command word to engine
- eng_wr  out  4  WR field to engine
- eng_din  in  32  read word from engine

Behaviour:
- Reset is asynchronous on rstn low. All outputs reset to 0. State resets to IDLE. Round-robin pointer (last) resets to 1, so requester 0 wins the first tie.
- State IDLE, on the first cycle any req bit is high:
  - Winner is the sole requester; if both request, winner is the requester not equal to last.
  - eng_dout and eng_wr latch the winner's data and wr.
  - gnt[winner] is set to 1.
  - Next state is LAUNCH.
- State LAUNCH: eng_start = 1 for exactly this one cycle; busy counter cleared; next state is WAIT_HI.
- State WAIT_HI:
  - eng_busy = 1 moves to WAIT_LO.
  - Otherwise the counter increments. When the counter reaches BUSY_WAIT: err_r = 1, rdata = 0, next state is DONE.
  - eng_busy already high in the LAUNCH cycle is ignored; only busy sampled in WAIT_HI counts.
- State WAIT_LO: eng_busy = 0 captures eng_din into rdata, sets err_r = 0, next state is DONE.
- State DONE:
  - done[winner] = 1 and err = err_r for one cycle.
  - gnt cleared; last = winner; next state is IDLE.
- Timing: latency from req to eng_start is 2 cycles (IDLE, LAUNCH). Back-to-back transfers leave at least 1 IDLE cycle between DONE and the next LAUNCH.
- Handshake rules:
  - A requester holds req, data and wr stable until it sees its done pulse.
  - Data changes after the IDLE latch cycle have no effect on the transfer in progress.
  - Deasserting req while granted does not abort the transfer; done still pulses.
  - req still high in the cycle after done counts as a new request and competes under round-robin.
- Outputs:
  - gnt and done are never both-hot.
  - eng_dout and eng_wr hold their last value after completion.
  - rdata and err hold until overwritten at the next DONE.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. No done pulse is generated for the aborted transfer.

Optional Feature:
- Macro: CC1200_SPI_ARB_TIMEOUT_EN
- Defined:
  - WAIT_LO runs a 16-bit counter cleared on entry.
  - If eng_busy is still high when the counter reaches TIMEOUT_CYCLES: rdata = 0, err_r = 1, next state is DONE, and the engine is abandoned.
  - A later busy fall is ignored. The next transfer's WAIT_HI accepts busy only after its own LAUNCH.
- Undefined: WAIT_LO waits indefinitely; err is raised only by the BUSY_WAIT expiry.

Test Plan:
- Single transfer: req = 01, req0_data = 32'hA5_0F_12_34, req0_wr = 4'h3; engine raises busy 1 cycle after start, holds 20 cycles, eng_din = 32'hDEADBEEF. Required: eng_start pulses 2 cycles after req; eng_dout = A50F1234; eng_wr = 3; done = 01 with err = 0 and rdata = DEADBEEF.
- Contention: req = 11 held across three transfers from reset. Required: grant order 0, 1, 0; each done one-hot; gnt never 11.
- Busy never rises, BUSY_WAIT = 8: req = 10. Required: done = 10 with err = 1 and rdata = 0 at 8 WAIT_HI cycles after eng_start; gnt clears.
- Mid-grant data change and req drop: req0_data changed and req deasserted while in WAIT_LO. Required: eng_dout unchanged; done = 01 still pulses.
- Reset mid-transfer: rstn low during WAIT_LO. Required: gnt, eng_start and done all 0 immediately; after release, a new req = 01 proceeds normally.
- With CC1200_SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100, busy stuck high: done pulses with err = 1 after 100 WAIT_LO cycles. Without the macro: no done pulse within 1000 cycles.
